// File: rtl/atconv_param_if.sv
// Bundles the image-ROM and layer-memory signals seen by the atrous-conv engine.
// The engine owns the master modport; the memory side connects through the slave modport.
interface atconv_param_if #(
    parameter int AW = 12
) ();
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [12:0]   idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [12:0]   cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [12:0]   cdata_rd;
    logic          csel;

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );
endinterface

// File: rtl/atconv_param.sv
// Parameterised atrous-conv engine: 3x3 dilated conv + bias + ReLU into layer 0, then 2x2 max-pool with ceil into layer 1.
// Define ATCONV_PARAM_SAT_EN to saturate positive layer-0 results at 0x0FFF instead of wrapping to 12 bits.
module atconv_param #(
    parameter int               IMG_W = 64,
    parameter int               DIL   = 2,
    parameter int               AW    = 2 * $clog2(IMG_W),
    parameter logic signed [12:0] W0   = 13'h1FFF,
    parameter logic signed [12:0] W1   = 13'h1FFE,
    parameter logic signed [12:0] W2   = 13'h1FFF,
    parameter logic signed [12:0] W3   = 13'h1FFC,
    parameter logic signed [12:0] W4   = 13'h0010,
    parameter logic signed [12:0] W5   = 13'h1FFC,
    parameter logic signed [12:0] W6   = 13'h1FFF,
    parameter logic signed [12:0] W7   = 13'h1FFE,
    parameter logic signed [12:0] W8   = 13'h1FFF,
    parameter logic signed [12:0] BIAS = 13'h1FF4
) (
    input  logic           clk,
    input  logic           reset,
    atconv_param_if.master bus
);
    localparam int unsigned LW    = $clog2(IMG_W);
    localparam int unsigned PW    = AW - 2;
    localparam int unsigned ACC_W = 30;

    typedef enum logic [2:0] {IDLE, CONV, CWR, POOL, PWR, DONE} state_t;

    state_t                   state;
    logic [3:0]               ph;
    logic [AW-1:0]            pix;
    logic [PW-1:0]            pidx;
    logic signed [ACC_W-1:0]  acc;
    logic [12:0]              mx;

    logic signed [12:0]       wsel;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  v;
    logic [12:0]              l0_val;
    logic [12:0]              mx_next;
    logic [12:0]              pool_val;
    logic [AW-1:0]            pix_nxt;
    logic [PW-1:0]            pidx_nxt;

    // Replicate padding: clamp one coordinate of a tap to the image edge.
    function automatic logic [LW-1:0] clamp_off(input logic [LW-1:0] x, input int sel);
        int t;
        t = int'(x) + (sel - 1) * DIL;
        if (t < 0) t = 0;
        else if (t > IMG_W - 1) t = IMG_W - 1;
        return LW'(t);
    endfunction

    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] k);
        return AW'({clamp_off(p[AW-1:LW], int'(k) / 3), clamp_off(p[LW-1:0], int'(k) % 3)});
    endfunction

    // Pool window word k: bit 1 picks the lower row, bit 0 the right column.
    function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] i, input logic [1:0] k);
        return AW'({i[PW-1:LW-1], k[1], i[LW-2:0], k[0]});
    endfunction

    always_comb begin
        wsel = W0;
        case (ph)
            4'd1:    wsel = W0;
            4'd2:    wsel = W1;
            4'd3:    wsel = W2;
            4'd4:    wsel = W3;
            4'd5:    wsel = W4;
            4'd6:    wsel = W5;
            4'd7:    wsel = W6;
            4'd8:    wsel = W7;
            4'd9:    wsel = W8;
            default: wsel = W0;
        endcase
        prod    = ACC_W'(signed'(bus.idata)) * ACC_W'(wsel);
        acc_sum = acc + prod;
        v       = (acc_sum >>> 4) + ACC_W'(BIAS);
        if (v < 0) begin
            l0_val = 13'd0;
        end
`ifdef ATCONV_PARAM_SAT_EN
        else if (v > 30'sh0FFF) begin
            l0_val = 13'h0FFF;
        end
`endif
        else begin
            l0_val = {1'b0, v[11:0]};
        end
        mx_next  = (bus.cdata_rd > mx) ? bus.cdata_rd : mx;
        pool_val = (mx_next[3:0] != 4'd0) ? {mx_next[12:4] + 9'd1, 4'd0} : mx_next;
        pix_nxt  = pix + AW'(1);
        pidx_nxt = pidx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ph           <= '0;
            pix          <= '0;
            pidx         <= '0;
            acc          <= '0;
            mx           <= '0;
            bus.busy     <= 1'b0;
            bus.iaddr    <= '0;
            bus.cwr      <= 1'b0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.crd      <= 1'b0;
            bus.caddr_rd <= '0;
            bus.csel     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ready) begin
                        state     <= CONV;
                        bus.busy  <= 1'b1;
                        ph        <= '0;
                        pix       <= '0;
                        acc       <= '0;
                        bus.iaddr <= tap_addr('0, 4'd0);
                    end
                end
                // Tap k is addressed in phase k and its pixel is accumulated in phase k+1.
                CONV: begin
                    if (ph != 4'd0) acc <= acc_sum;
                    if (ph == 4'd9) begin
                        state        <= CWR;
                        ph           <= 4'd10;
                        bus.cwr      <= 1'b1;
                        bus.csel     <= 1'b0;
                        bus.caddr_wr <= pix;
                        bus.cdata_wr <= l0_val;
                    end else begin
                        ph <= ph + 4'd1;
                        if (ph < 4'd8) bus.iaddr <= tap_addr(pix, ph + 4'd1);
                    end
                end
                CWR: begin
                    bus.cwr <= 1'b0;
                    acc     <= '0;
                    ph      <= '0;
                    if (pix == '1) begin
                        state        <= POOL;
                        pidx         <= '0;
                        mx           <= '0;
                        bus.crd      <= 1'b1;
                        bus.caddr_rd <= rd_addr('0, 2'd0);
                    end else begin
                        state     <= CONV;
                        pix       <= pix_nxt;
                        bus.iaddr <= tap_addr(pix_nxt, 4'd0);
                    end
                end
                // Four reads in phases 0-3, data folded into the max in phases 1-4.
                POOL: begin
                    if (ph != 4'd0) mx <= mx_next;
                    if (ph == 4'd4) begin
                        state        <= PWR;
                        ph           <= 4'd5;
                        bus.cwr      <= 1'b1;
                        bus.csel     <= 1'b1;
                        bus.caddr_wr <= AW'(pidx);
                        bus.cdata_wr <= pool_val;
                    end else begin
                        ph <= ph + 4'd1;
                        if (ph == 4'd3) bus.crd <= 1'b0;
                        else bus.caddr_rd <= rd_addr(pidx, ph[1:0] + 2'd1);
                    end
                end
                PWR: begin
                    bus.cwr  <= 1'b0;
                    bus.csel <= 1'b0;
                    ph       <= '0;
                    mx       <= '0;
                    if (pidx == '1) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end else begin
                        state        <= POOL;
                        pidx         <= pidx_nxt;
                        bus.crd      <= 1'b1;
                        bus.caddr_rd <= rd_addr(pidx_nxt, 2'd0);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atconv_param.sv
// Bench for atconv_param: a 64x64/DIL=2 engine and an 8x8/DIL=1 engine against an arithmetic reference model.
module tb_atconv_param;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    atconv_param_if #(.AW(12)) b64 ();
    atconv_param_if #(.AW(6))  b8 ();

    atconv_param #(.IMG_W(64), .DIL(2), .AW(12)) u64 (.clk(clk), .reset(reset), .bus(b64.master));
    atconv_param #(.IMG_W(8),  .DIL(1), .AW(6))  u8  (.clk(clk), .reset(reset), .bus(b8.master));

    logic [12:0] img [2][4096];
    logic [12:0] l0m [2][4096];
    logic [12:0] l1m [2][4096];
    logic [12:0] l0x [2][4096];
    logic [12:0] l1x [2][4096];
    int          wt  [9] = '{-1, -2, -1, -4, 16, -4, -1, -2, -1};
    int          wc0 [2];
    int          wc1 [2];
    int          bc  [2];

    typedef struct {
        int          d;
        int          layer;
        int          r;
        int          c;
        logic [12:0] exp;
    } vec_t;
    vec_t tv [9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Image ROM and two-bank layer memory, both one-cycle registered.
    always @(posedge clk) begin
        b64.idata <= img[0][b64.iaddr];
        if (b64.crd) b64.cdata_rd <= b64.csel ? l1m[0][b64.caddr_rd] : l0m[0][b64.caddr_rd];
        if (b64.cwr) begin
            if (b64.csel) l1m[0][b64.caddr_wr] <= b64.cdata_wr;
            else          l0m[0][b64.caddr_wr] <= b64.cdata_wr;
        end
    end

    always @(posedge clk) begin
        b8.idata <= img[1][b8.iaddr];
        if (b8.crd) b8.cdata_rd <= b8.csel ? l1m[1][b8.caddr_rd] : l0m[1][b8.caddr_rd];
        if (b8.cwr) begin
            if (b8.csel) l1m[1][b8.caddr_wr] <= b8.cdata_wr;
            else         l0m[1][b8.caddr_wr] <= b8.cdata_wr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int x, input int w);
        if (x < 0) return 0;
        if (x > w - 1) return w - 1;
        return x;
    endfunction

    // Layer-0 reference: weighted sum in Q.8, floor to Q.4, bias, ReLU, 12-bit wrap or saturate.
    function automatic logic [12:0] l0_ref(input int d, input int w, input int dil, input int r, input int c);
        int acc;
        int v;
        int a;
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            a = clampi(r + (k / 3 - 1) * dil, w) * w + clampi(c + (k % 3 - 1) * dil, w);
            acc += int'($signed(img[d][a])) * wt[k];
        end
        v = (acc >>> 4) - 12;
        if (v < 0) return 13'd0;
`ifdef ATCONV_PARAM_SAT_EN
        if (v > 4095) return 13'h0FFF;
`endif
        return 13'(v % 4096);
    endfunction

    task automatic build_model();
        int w;
        int dil;
        int m;
        for (int d = 0; d < 2; d++) begin
            w   = (d == 0) ? 64 : 8;
            dil = (d == 0) ? 2 : 1;
            for (int r = 0; r < w; r++)
                for (int c = 0; c < w; c++)
                    l0x[d][r * w + c] = l0_ref(d, w, dil, r, c);
            for (int p = 0; p < w / 2; p++)
                for (int q = 0; q < w / 2; q++) begin
                    m = 0;
                    for (int i = 0; i < 4; i++)
                        if (int'(l0x[d][(2 * p + i / 2) * w + 2 * q + i % 2]) > m)
                            m = int'(l0x[d][(2 * p + i / 2) * w + 2 * q + i % 2]);
                    l1x[d][p * (w / 2) + q] = 13'((m + 15) / 16 * 16);
                end
        end
    endtask

    // Every write is checked against the model, in order.
    task automatic mon(input int d, input logic busy, cwr, crd, csel,
                       input logic [11:0] addr, input logic [12:0] data);
        if (cwr) chk($sformatf("rw_exclusive[%0d]", d), 32'(crd), 32'd0);
        if (cwr && !csel) begin
            chk($sformatf("l0_addr[%0d]", d), 32'(addr), 32'(wc0[d]));
            chk($sformatf("l0_data[%0d] @%0d", d, wc0[d]), 32'(data), 32'(l0x[d][wc0[d] % 4096]));
            wc0[d]++;
        end
        if (cwr && csel) begin
            chk($sformatf("l1_addr[%0d]", d), 32'(addr), 32'(wc1[d]));
            chk($sformatf("l1_data[%0d] @%0d", d, wc1[d]), 32'(data), 32'(l1x[d][wc1[d] % 4096]));
            wc1[d]++;
        end
        if (busy) bc[d]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon(0, b64.busy, b64.cwr, b64.crd, b64.csel, b64.caddr_wr, b64.cdata_wr);
        mon(1, b8.busy, b8.cwr, b8.crd, b8.csel, 12'(b8.caddr_wr), b8.cdata_wr);
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            wc0[d] = 0;
            wc1[d] = 0;
            bc[d]  = 0;
        end
    endtask

    initial begin
        int i;
        logic [12:0] act;
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        b64.ready = 1'b0;
        b8.ready  = 1'b0;
        clear_counts();

        // Impulse, corner impulse, overflow pattern and a random band, all far enough apart not to interact.
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 4096; a++) begin
                img[d][a] = 13'd0;
                l0m[d][a] = 13'd0;
                l1m[d][a] = 13'd0;
            end
        img[0][10 * 64 + 10] = 13'h0100;
        img[0][0]            = 13'h0100;
        img[0][20 * 64 + 20] = 13'h0FFF;
        for (int dr = -2; dr <= 2; dr += 2)
            for (int dc = -2; dc <= 2; dc += 2)
                if (dr != 0 || dc != 0) img[0][(20 + dr) * 64 + 20 + dc] = 13'h1000;
        for (int a = 40 * 64; a < 4096; a++) img[0][a] = 13'($urandom_range(0, 8191));
        img[1][3 * 8 + 3] = 13'h0100;
        build_model();

        tv[0] = '{0, 0, 10, 10, 13'h00F4};
        tv[1] = '{0, 0, 10, 12, 13'h0000};
        tv[2] = '{0, 0, 12, 12, 13'h0000};
        tv[3] = '{0, 1, 5, 5, 13'h0100};
        tv[4] = '{0, 0, 0, 0, 13'h0084};
        tv[5] = '{0, 1, 0, 0, 13'h0090};
`ifdef ATCONV_PARAM_SAT_EN
        tv[6] = '{0, 0, 20, 20, 13'h0FFF};
`else
        tv[6] = '{0, 0, 20, 20, 13'h0FF3};
`endif
        tv[7] = '{1, 0, 3, 3, 13'h00F4};
        tv[8] = '{1, 1, 1, 1, 13'h0100};

        repeat (3) tick();
        chk("rst_busy", 32'(b64.busy), 32'd0);
        chk("rst_cwr", 32'(b64.cwr), 32'd0);
        chk("rst_crd", 32'(b64.crd), 32'd0);
        chk("rst_csel", 32'(b64.csel), 32'd0);
        chk("rst_iaddr", 32'(b64.iaddr), 32'd0);
        chk("rst_caddr_wr", 32'(b64.caddr_wr), 32'd0);
        chk("rst_caddr_rd", 32'(b64.caddr_rd), 32'd0);
        chk("rst_cdata_wr", 32'(b64.cdata_wr), 32'd0);
        chk("rst_busy8", 32'(b8.busy), 32'd0);
        reset = 1'b0;
        tick();

        // Run that gets aborted by reset at cycle 1000.
        b64.ready = 1'b1;
        tick();
        b64.ready = 1'b0;
        chk("start_busy", 32'(b64.busy), 32'd1);
        chk("start_iaddr_tap0", 32'(b64.iaddr), 32'd0);
        repeat (998) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(b64.busy), 32'd0);
        chk("abort_cwr", 32'(b64.cwr), 32'd0);
        chk("abort_crd", 32'(b64.crd), 32'd0);
        repeat (5) tick();
        chk("idle_after_abort", 32'(b64.busy), 32'd0);

        // Full run on both engines, with a stray ready pulse mid-run.
        clear_counts();
        b64.ready = 1'b1;
        b8.ready  = 1'b1;
        tick();
        b64.ready = 1'b0;
        b8.ready  = 1'b0;
        i = 0;
        while ((b64.busy || b8.busy) && i < 60000) begin
            b64.ready = (i == 2000);
            b8.ready  = (i == 300);
            tick();
            i++;
        end
        b64.ready = 1'b0;
        b8.ready  = 1'b0;
        chk("run_terminates", 32'(b64.busy || b8.busy), 32'd0);
        chk("busy_cycles64", 32'(bc[0]), 32'(64 * 64 * 11 + 32 * 32 * 6));
        chk("busy_cycles8", 32'(bc[1]), 32'(8 * 8 * 11 + 4 * 4 * 6));
        chk("l0_writes64", 32'(wc0[0]), 32'd4096);
        chk("l1_writes64", 32'(wc1[0]), 32'd1024);
        chk("l0_writes8", 32'(wc0[1]), 32'd64);
        chk("l1_writes8", 32'(wc1[1]), 32'd16);
        repeat (4) tick();
        chk("stays_idle", 32'(b64.busy), 32'd0);
        chk("idle_cwr", 32'(b64.cwr), 32'd0);

        for (int k = 0; k < 9; k++) begin
            if (tv[k].layer == 1)
                act = l1m[tv[k].d][tv[k].r * ((tv[k].d == 0) ? 32 : 4) + tv[k].c];
            else
                act = l0m[tv[k].d][tv[k].r * ((tv[k].d == 0) ? 64 : 8) + tv[k].c];
            chk($sformatf("vec%0d L%0d(%0d,%0d)", k, tv[k].layer, tv[k].r, tv[k].c), 32'(act), 32'(tv[k].exp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
